// File: rtl/crossing_requester.sv
`default_nettype none
// ============================================================================
// Module   : crossing_requester
// Purpose  : Initiator side of the traffic-light "change" handshake. Debounces
//            a pedestrian push-button, issues a one-CLK change pulse to the
//            controller, then treats the red lamp as the acknowledge. Enforces
//            a minimum gap between served requests and flags a sticky fault on
//            acknowledge timeout or an illegal lamp combination.
// Ports    : CLK        - 10 kHz clock, rising edge
//            reset      - asynchronous, active-low reset
//            en         - block enable, 0 forces IDLE
//            button     - raw push-button, high = pressed
//            green/yellow/red - observed lamps, asynchronous to CLK
//            change     - one-CLK request pulse to the controller
//            busy       - high from accepted press until holdoff ends
//            fault      - sticky timeout / illegal-lamp flag
//            req_count  - served-request counter, saturates at 255
// Options  : REQ_QUEUE_EN - when defined, one press arriving while a request
//            is in flight is remembered and re-armed automatically.
// Revision : 1.0 - initial release
// ============================================================================
module crossing_requester #(
    parameter int CLK_PER_MS     = 10,
    parameter int DEBOUNCE_MS    = 20,
    parameter int MIN_GAP_MS     = 5000,
    parameter int ACK_TIMEOUT_MS = 8000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en,
    input  logic       button,
    input  logic       green,
    input  logic       yellow,
    input  logic       red,
    output logic       change,
    output logic       busy,
    output logic       fault,
    output logic [7:0] req_count
);

    localparam int c_PRE_W = $clog2(CLK_PER_MS + 1);
    localparam int c_DEB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int c_GAP_W = $clog2(MIN_GAP_MS + 1);
    localparam int c_TO_W  = $clog2(ACK_TIMEOUT_MS + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_PER_MS - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_MS - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_MAX  = c_DEB_W'(DEBOUNCE_MS);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX  = c_GAP_W'(MIN_GAP_MS);
    localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(ACK_TIMEOUT_MS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_HOLDOFF  = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [c_PRE_W-1:0] r_presc;
    logic [c_DEB_W-1:0] r_deb;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_TO_W-1:0]  r_to;
    logic [7:0]         r_req_count;
    logic               r_multi_d;
    logic               w_btn_s, w_grn_s, w_yel_s, w_red_s;
    logic               w_tick, w_press, w_multi, w_illegal, w_served, w_pend;

    // Two-flop synchronizers, bit order {red, yellow, green, button}
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {red, yellow, green, button};
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2[0];
    assign w_grn_s = r_sync2[1];
    assign w_yel_s = r_sync2[2];
    assign w_red_s = r_sync2[3];

    // Millisecond prescaler, free-running out of reset
    assign w_tick = (r_presc == c_PRE_LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    // Debounce: saturates at DEBOUNCE_MS so a held button yields one event;
    // a single low CLK re-arms it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                       r_deb <= '0;
        else if (!en || !w_btn_s)         r_deb <= '0;
        else if (w_tick && r_deb != c_DEB_MAX) r_deb <= r_deb + 1'b1;
    end

    assign w_press = en && w_btn_s && w_tick && (r_deb == c_DEB_LAST);

    // Illegal lamps must persist two CLKs to reject one-cycle sync skew
    assign w_multi   = (w_grn_s & w_yel_s) | (w_grn_s & w_red_s) | (w_yel_s & w_red_s);
    assign w_illegal = w_multi & r_multi_d;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_multi_d <= 1'b0;
        else        r_multi_d <= w_multi;
    end

    // Next-state logic; enable dominates, illegal lamps override the rest
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_press || w_pend) w_next = S_ARM;
            S_ARM: begin
                if (w_red_s)                 w_next = w_pend ? S_ARM : S_IDLE;
                else if (r_gap == c_GAP_MAX) w_next = S_ISSUE;
            end
            S_ISSUE:    w_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (w_red_s)               w_next = S_HOLDOFF;
                else if (r_to == c_TO_MAX) w_next = S_FAULT;
            end
            S_HOLDOFF:  if (!w_red_s) w_next = w_pend ? S_ARM : S_IDLE;
            S_FAULT:    w_next = S_FAULT;
            default:    w_next = S_IDLE;
        endcase
        if (w_illegal) w_next = S_FAULT;
        if (!en)       w_next = S_IDLE;
    end

    assign w_served = (r_state == S_WAIT_ACK) && (w_next == S_HOLDOFF);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Gap timer: preloaded full so the first request is not delayed
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                             r_gap <= c_GAP_MAX;
        else if (w_served)                      r_gap <= '0;
        else if (w_tick && r_gap != c_GAP_MAX)  r_gap <= r_gap + 1'b1;
    end

    // Acknowledge timeout counter
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                    r_to <= '0;
        else if (r_state == S_ISSUE)   r_to <= '0;
        else if (r_state == S_WAIT_ACK && w_tick && r_to != c_TO_MAX)
                                       r_to <= r_to + 1'b1;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                             r_req_count <= 8'd0;
        else if (w_served && r_req_count != 8'hFF) r_req_count <= r_req_count + 8'd1;
    end

`ifdef REQ_QUEUE_EN
    logic r_pend;
    logic w_press_busy;
    logic w_pend_use;

    assign w_press_busy = w_press && (r_state == S_ARM || r_state == S_ISSUE ||
                                      r_state == S_WAIT_ACK || r_state == S_HOLDOFF);
    // The flag is consumed on any transition that only a pending press causes
    assign w_pend_use   = r_pend && (w_next == S_ARM) &&
                          ((r_state == S_HOLDOFF) || (r_state == S_IDLE) ||
                           (r_state == S_ARM && w_red_s));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            r_pend <= 1'b0;
        else if (!en || r_state == S_FAULT || w_next == S_FAULT)
            r_pend <= 1'b0;
        else
            r_pend <= (r_pend && !w_pend_use) || w_press_busy;
    end

    assign w_pend = r_pend;
`else
    assign w_pend = 1'b0;
`endif

    assign change    = (r_state == S_ISSUE);
    assign busy      = (r_state == S_ARM) || (r_state == S_ISSUE) ||
                       (r_state == S_WAIT_ACK) || (r_state == S_HOLDOFF);
    assign fault     = (r_state == S_FAULT);
    assign req_count = r_req_count;

endmodule
`default_nettype wire

// File: tb/tb_crossing_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossing_requester
// Purpose  : Directed self-checking bench for crossing_requester. The main
//            instance uses CLK_PER_MS=10, DEBOUNCE_MS=20, MIN_GAP_MS=50,
//            ACK_TIMEOUT_MS=80; a second, fast-timed instance drives 260
//            served requests to exercise counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossing_requester;

    logic       CLK    = 1'b0;
    logic       reset  = 1'b0;
    logic       en     = 1'b1;
    logic       button = 1'b0;
    logic       green  = 1'b0;
    logic       yellow = 1'b0;
    logic       red    = 1'b0;
    logic       change, busy, fault;
    logic [7:0] req_count;

    logic       btn2 = 1'b0;
    logic       red2 = 1'b0;
    logic       change2, busy2, fault2;
    logic [7:0] req_count2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    crossing_requester #(
        .CLK_PER_MS(10), .DEBOUNCE_MS(20), .MIN_GAP_MS(50), .ACK_TIMEOUT_MS(80)
    ) u_dut (
        .CLK(CLK), .reset(reset), .en(en), .button(button),
        .green(green), .yellow(yellow), .red(red),
        .change(change), .busy(busy), .fault(fault), .req_count(req_count)
    );

    crossing_requester #(
        .CLK_PER_MS(2), .DEBOUNCE_MS(1), .MIN_GAP_MS(1), .ACK_TIMEOUT_MS(8)
    ) u_fast (
        .CLK(CLK), .reset(reset), .en(1'b1), .button(btn2),
        .green(1'b0), .yellow(1'b0), .red(red2),
        .change(change2), .busy(busy2), .fault(fault2), .req_count(req_count2)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // which: 0 change, 1 change2, 2 busy high, 3 busy2 low, 4 fault high
    task automatic wait_for(input int which, input int budget, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            case (which)
                0:       hit = (change === 1'b1);
                1:       hit = (change2 === 1'b1);
                2:       hit = (busy === 1'b1);
                3:       hit = (busy2 === 1'b0);
                default: hit = (fault === 1'b1);
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic watch(input int n, output int pulses, output int busy_hi);
        pulses  = 0;
        busy_hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (change === 1'b1) pulses++;
            if (busy === 1'b1)   busy_hi++;
        end
    endtask

    task automatic serve(output int t_red);
        green = 1'b0;
        red   = 1'b1;
        t_red = cyc;
        step(50);
        red   = 1'b0;
        green = 1'b1;
        step(5);
    endtask

    initial begin
        int t0, t_r, at, at2, pulses, busy_hi, p_tot, b_tot, misses;

        // Reset state
        step(3);
        chk("rst_change", change, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", req_count, 0);
        reset = 1'b1;
        step(5);

        // Basic request
        green  = 1'b1;
        button = 1'b1;
        t0     = cyc;
        wait_for(0, 400, at);
        chk("basic_latency", (at >= t0 + 188) && (at <= t0 + 212), 1);
        chk("basic_busy", busy, 1);
        step(1);
        chk("basic_width", change, 0);
        watch(49, pulses, busy_hi);
        chk("basic_single", pulses, 0);
        button = 1'b0;
        step(50);
        green = 1'b0;
        red   = 1'b1;
        t_r   = cyc;
        step(5);
        chk("basic_served", req_count, 1);
        chk("basic_hold_busy", busy, 1);
        step(95);
        red   = 1'b0;
        green = 1'b1;
        step(5);
        chk("basic_release", busy, 0);

        // Minimum gap measured from holdoff entry
        button = 1'b1;
        wait_for(0, 700, at);
        chk("gap_delay", (at >= t_r + 490) && (at <= t_r + 510), 1);
        button = 1'b0;
        serve(t_r);
        chk("gap_served", req_count, 2);
        chk("gap_idle", busy, 0);

        // Bounce: 5 ms toggles never qualify
        p_tot = 0;
        b_tot = 0;
        for (int k = 0; k < 20; k++) begin
            button = ~button;
            watch(50, pulses, busy_hi);
            p_tot += pulses;
            b_tot += busy_hi;
        end
        chk("bounce_pulses", p_tot, 0);
        chk("bounce_busy", b_tot, 0);
        button = 1'b1;
        watch(600, pulses, busy_hi);
        chk("steady_single", pulses, 1);
        button = 1'b0;
        serve(t_r);
        chk("steady_served", req_count, 3);

        // Acknowledge timeout
        button = 1'b1;
        wait_for(0, 800, at);
        step(30);
        button = 1'b0;
        wait_for(4, 900, at2);
        chk("timeout_time", (at != -1) && (at2 >= at + 786) && (at2 <= at + 808), 1);
        chk("fault_busy", busy, 0);
        chk("fault_change", change, 0);
        step(50);
        chk("fault_sticky", fault, 1);
        en = 1'b0;
        step(1);
        en = 1'b1;
        chk("en_clears_fault", fault, 0);
        chk("en_clears_busy", busy, 0);
        step(2);
        chk("idle_after_en", fault, 0);
        chk("timeout_count_held", req_count, 3);

        // Red already on
        green = 1'b0;
        red   = 1'b1;
        step(5);
        button = 1'b1;
        wait_for(2, 300, at);
        chk("redon_busy_seen", at != -1, 1);
        watch(20, pulses, busy_hi);
        chk("redon_no_change", pulses, 0);
        chk("redon_busy_drop", busy, 0);
        chk("redon_count", req_count, 3);
        button = 1'b0;

        // Illegal lamps: one-cycle overlap tolerated, two cycles fault
        step(5);
        green = 1'b1;
        step(1);
        green = 1'b0;
        step(6);
        chk("glitch_no_fault", fault, 0);
        green = 1'b1;
        step(2);
        green = 1'b0;
        step(6);
        chk("illegal_fault", fault, 1);
        en = 1'b0;
        step(1);
        en    = 1'b1;
        red   = 1'b0;
        green = 1'b1;
        step(5);
        chk("illegal_cleared", fault, 0);

        // Asynchronous reset mid WAIT_ACK
        button = 1'b1;
        wait_for(0, 800, at);
        chk("pre_reset_change", at != -1, 1);
        button = 1'b0;
        step(20);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_count", req_count, 3);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outs", {change, busy, fault}, 0);
        chk("async_reset_count", req_count, 0);
        step(2);
        reset = 1'b1;
        step(5);

        // Saturation on the fast instance
        misses = 0;
        for (int i = 1; i <= 260; i++) begin
            btn2 = 1'b1;
            wait_for(1, 40, at);
            if (at == -1) misses++;
            btn2 = 1'b0;
            red2 = 1'b1;
            step(4);
            red2 = 1'b0;
            wait_for(3, 20, at);
            if (at == -1) misses++;
            if (i == 100) chk("sat_mid", req_count2, 100);
        end
        chk("sat_final", req_count2, 255);
        chk("sat_handshakes", misses, 0);
        chk("sat_no_fault", fault2, 0);

`ifdef REQ_QUEUE_EN
        // Press during WAIT_ACK is replayed after the gap
        green  = 1'b1;
        button = 1'b1;
        wait_for(0, 400, at);
        chk("q_first", at != -1, 1);
        step(30);
        button = 1'b0;
        step(5);
        button = 1'b1;
        step(250);
        button = 1'b0;
        serve(t_r);
        chk("q_rearmed_busy", busy, 1);
        wait_for(0, 800, at);
        chk("q_second", (at >= t_r + 490) && (at <= t_r + 510), 1);
        serve(t_r);
        chk("q_count", req_count, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
